// File: rtl/mem_ctrl_if.sv
// Request/response channels and byte-wide RAM/IO port of mem_ctrl.
// The core side drives requests and mem_din; mem_ctrl (slave) drives responses and the bus.
interface mem_ctrl_if;
   logic        rdy;
   logic        in_xbp;
   logic        in_rob_store_flag;
   logic [5:0]  in_rob_store_size;
   logic [31:0] in_rob_store_addr;
   logic [31:0] in_rob_store_data;
   logic        in_rob_io_read_flag;
   logic        out_rob_done;
   logic [31:0] out_rob_data;
   logic        in_lsb_flag;
   logic [5:0]  in_lsb_size;
   logic [31:0] in_lsb_addr;
   logic        out_lsb_done;
   logic [31:0] out_lsb_data;
   logic        in_fetch_flag;
   logic [31:0] in_fetch_addr;
   logic        out_fetch_done;
   logic [31:0] out_fetch_data;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   modport slave (
      input  rdy, in_xbp,
      input  in_rob_store_flag, in_rob_store_size, in_rob_store_addr, in_rob_store_data,
      input  in_rob_io_read_flag,
      output out_rob_done, out_rob_data,
      input  in_lsb_flag, in_lsb_size, in_lsb_addr,
      output out_lsb_done, out_lsb_data,
      input  in_fetch_flag, in_fetch_addr,
      output out_fetch_done, out_fetch_data,
      input  mem_din, io_buffer_full,
      output mem_dout, mem_a, mem_wr
   );

   modport master (
      output rdy, in_xbp,
      output in_rob_store_flag, in_rob_store_size, in_rob_store_addr, in_rob_store_data,
      output in_rob_io_read_flag,
      input  out_rob_done, out_rob_data,
      output in_lsb_flag, in_lsb_size, in_lsb_addr,
      input  out_lsb_done, out_lsb_data,
      output in_fetch_flag, in_fetch_addr,
      input  out_fetch_done, out_fetch_data,
      output mem_din, io_buffer_full,
      input  mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: serializes ROB/LSB/fetch requests into byte accesses on the RAM/IO port.
// Define MEM_CTRL_IO_STALL_EN to hold IO-window write bytes while io_buffer_full is set.
module mem_ctrl #(
   parameter logic [31:0] IO_READ_ADDR = 32'h30000,
   parameter logic [31:0] IO_WIN_LO    = 32'h30000
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;
   typedef enum logic [1:0] {SrcRob, SrcLsb, SrcFetch} src_e;

   state_e      state_q;
   src_e        src_q;
   logic        rob_pend_q, rob_store_q, lsb_pend_q, fetch_pend_q;
   logic [31:0] rob_addr_q, rob_data_q, lsb_addr_q, fetch_addr_q;
   logic [2:0]  rob_len_q, lsb_len_q;
   logic [2:0]  len_q, cnt_q;
   logic [31:0] wdata_q, rdata_q, rdata_d;
   logic [31:0] mem_a_q;
   logic [7:0]  mem_dout_q;
   logic        mem_wr_q;
   logic        rob_done_q, lsb_done_q, fetch_done_q;
   logic [31:0] rob_rdata_q, lsb_rdata_q, fetch_rdata_q;
   logic        io_stall;

   function automatic logic [2:0] len_of(input logic [5:0] size);
      case (size)
         6'd1:    return 3'd1;
         6'd2:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

`ifdef MEM_CTRL_IO_STALL_EN
   assign io_stall = (state_q == StWrite) && (mem_a_q >= IO_WIN_LO) && bus.io_buffer_full;
`else
   logic unused_io_full;
   assign unused_io_full = bus.io_buffer_full ^ (^IO_WIN_LO);
   assign io_stall       = 1'b0;
`endif

   // In READ, cnt_q = k >= 1 means mem_din carries byte k-1.
   always_comb begin
      rdata_d = rdata_q;
      case (cnt_q)
         3'd1:    rdata_d[7:0]   = bus.mem_din;
         3'd2:    rdata_d[15:8]  = bus.mem_din;
         3'd3:    rdata_d[23:16] = bus.mem_din;
         3'd4:    rdata_d[31:24] = bus.mem_din;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         src_q         <= SrcRob;
         rob_pend_q    <= 1'b0;
         rob_store_q   <= 1'b0;
         lsb_pend_q    <= 1'b0;
         fetch_pend_q  <= 1'b0;
         rob_addr_q    <= '0;
         rob_data_q    <= '0;
         lsb_addr_q    <= '0;
         fetch_addr_q  <= '0;
         rob_len_q     <= '0;
         lsb_len_q     <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         mem_a_q       <= '0;
         mem_dout_q    <= '0;
         mem_wr_q      <= 1'b0;
         rob_done_q    <= 1'b0;
         lsb_done_q    <= 1'b0;
         fetch_done_q  <= 1'b0;
         rob_rdata_q   <= '0;
         lsb_rdata_q   <= '0;
         fetch_rdata_q <= '0;
      end else if (bus.rdy) begin
         if (bus.in_rob_store_flag) begin
            rob_pend_q  <= 1'b1;
            rob_store_q <= 1'b1;
            rob_addr_q  <= bus.in_rob_store_addr;
            rob_data_q  <= bus.in_rob_store_data;
            rob_len_q   <= len_of(bus.in_rob_store_size);
         end else if (bus.in_rob_io_read_flag) begin
            rob_pend_q  <= 1'b1;
            rob_store_q <= 1'b0;
            rob_addr_q  <= IO_READ_ADDR;
            rob_len_q   <= 3'd1;
         end
         if (bus.in_xbp) begin
            lsb_pend_q <= 1'b0;
         end else if (bus.in_lsb_flag) begin
            lsb_pend_q <= 1'b1;
            lsb_addr_q <= bus.in_lsb_addr;
            lsb_len_q  <= len_of(bus.in_lsb_size);
         end
         if (bus.in_xbp) begin
            fetch_pend_q <= 1'b0;
         end else if (bus.in_fetch_flag) begin
            fetch_pend_q <= 1'b1;
            fetch_addr_q <= bus.in_fetch_addr;
         end
         rob_done_q   <= 1'b0;
         lsb_done_q   <= 1'b0;
         fetch_done_q <= 1'b0;

         unique case (state_q)
            StIdle: begin
               cnt_q   <= '0;
               rdata_q <= '0;
               if (rob_pend_q) begin
                  rob_pend_q <= 1'b0;
                  src_q      <= SrcRob;
                  len_q      <= rob_len_q;
                  mem_a_q    <= rob_addr_q;
                  if (rob_store_q) begin
                     state_q    <= StWrite;
                     mem_wr_q   <= 1'b1;
                     mem_dout_q <= rob_data_q[7:0];
                     wdata_q    <= {8'b0, rob_data_q[31:8]};
                  end else begin
                     state_q <= StRead;
                  end
               end else if (lsb_pend_q && !bus.in_xbp) begin
                  lsb_pend_q <= 1'b0;
                  src_q      <= SrcLsb;
                  len_q      <= lsb_len_q;
                  mem_a_q    <= lsb_addr_q;
                  state_q    <= StRead;
               end else if (fetch_pend_q && !bus.in_xbp) begin
                  fetch_pend_q <= 1'b0;
                  src_q        <= SrcFetch;
                  len_q        <= 3'd4;
                  mem_a_q      <= fetch_addr_q;
                  state_q      <= StRead;
               end
            end
            StWrite: begin
               if (!io_stall) begin
                  if (cnt_q == len_q - 3'd1) begin
                     state_q    <= StDone;
                     mem_wr_q   <= 1'b0;
                     rob_done_q <= 1'b1;
                  end else begin
                     cnt_q      <= cnt_q + 3'd1;
                     mem_a_q    <= mem_a_q + 32'd1;
                     mem_dout_q <= wdata_q[7:0];
                     wdata_q    <= {8'b0, wdata_q[31:8]};
                  end
               end
            end
            StRead: begin
               // Committed ROB reads are never flushed.
               if (bus.in_xbp && src_q != SrcRob) begin
                  state_q <= StIdle;
               end else if (cnt_q == len_q) begin
                  state_q <= StDone;
                  unique case (src_q)
                     SrcRob: begin
                        rob_done_q  <= 1'b1;
                        rob_rdata_q <= rdata_d;
                     end
                     SrcLsb: begin
                        lsb_done_q  <= 1'b1;
                        lsb_rdata_q <= rdata_d;
                     end
                     default: begin
                        fetch_done_q  <= 1'b1;
                        fetch_rdata_q <= rdata_d;
                     end
                  endcase
               end else begin
                  rdata_q <= rdata_d;
                  cnt_q   <= cnt_q + 3'd1;
                  if (cnt_q + 3'd1 != len_q) mem_a_q <= mem_a_q + 32'd1;
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.mem_a          = mem_a_q;
   assign bus.mem_dout       = mem_dout_q;
   assign bus.mem_wr         = mem_wr_q & bus.rdy & ~io_stall;
   assign bus.out_rob_done   = rob_done_q & bus.rdy;
   assign bus.out_lsb_done   = lsb_done_q & bus.rdy;
   assign bus.out_fetch_done = fetch_done_q & bus.rdy;
   assign bus.out_rob_data   = rob_rdata_q;
   assign bus.out_lsb_data   = lsb_rdata_q;
   assign bus.out_fetch_data = fetch_rdata_q;

endmodule
